// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fd_hold_buffer.sv
// One-entry skid register that parks a fetched instruction while decode is stalled.
module fd_hold_buffer
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pc4_in,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
            pc4   <= pc4_in;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage: PC register, single-outstanding imem handshake, kill flag and IF/ID register.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] pc, pc_n, pc_plus4, req_addr, target;
    logic            kill, kill_n;
    logic            ifid_load_mem, ifid_load_hold, pc_advance;
    logic            hb_load, hb_clear, hb_valid;
    logic [31:0]     hb_instr;
    logic [XLEN-1:0] hb_pc, hb_pc4;

    assign pc_plus4  = pc + XLEN'(4);
    assign target    = {PCTargetE[XLEN-1:2], 2'b00};
    assign imem_addr = req_addr;

    always_comb begin
        state_n        = state;
        kill_n         = kill;
        imem_req       = 1'b0;
        ifid_load_mem  = 1'b0;
        ifid_load_hold = 1'b0;
        pc_advance     = 1'b0;
        hb_load        = 1'b0;
        hb_clear       = 1'b0;
        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (PCSrcE)   kill_n  = 1'b1;
                if (imem_gnt) state_n = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_n = REQ;
                    // A redirect in the same cycle as the response kills it outright.
                    if (kill || PCSrcE) begin
                        kill_n = 1'b0;
                    end else if (StallD) begin
                        hb_load = 1'b1;
                        state_n = HOLD;
                    end else begin
                        ifid_load_mem = 1'b1;
                        pc_advance    = 1'b1;
                    end
                end else if (PCSrcE) begin
                    kill_n = 1'b1;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    hb_clear = 1'b1;
                    state_n  = REQ;
                end else if (!StallD && hb_valid) begin
                    ifid_load_hold = 1'b1;
                    hb_clear       = 1'b1;
                    pc_advance     = 1'b1;
                    state_n        = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
        pc_n = PCSrcE ? target : (pc_advance ? pc_plus4 : pc);
    end

    // Request address is latched on entry to REQ so it stays stable until granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            req_addr <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            kill  <= kill_n;
            if (state_n == REQ && state != REQ) req_addr <= pc_n;
        end
    end

    fd_hold_buffer #(.XLEN(XLEN)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hb_load),
        .clear    (hb_clear),
        .instr_in (imem_rdata),
        .pc_in    (pc),
        .pc4_in   (pc_plus4),
        .valid    (hb_valid),
        .instr    (hb_instr),
        .pc       (hb_pc),
        .pc4      (hb_pc4)
    );

    // IF/ID register: flush > load > hold-on-stall > bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (ifid_load_mem) begin
            InstrD   <= imem_rdata;
            PCD      <= pc;
            PCPlus4D <= pc_plus4;
            ValidD   <= 1'b1;
        end else if (ifid_load_hold) begin
            InstrD   <= hb_instr;
            PCD      <= hb_pc;
            PCPlus4D <= hb_pc4;
            ValidD   <= 1'b1;
        end else if (!StallD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: handshake, stall/hold, redirect/kill, flush, wrap, reset.
module tb_fetch_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst2 = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] InstrD, InstrD2, PCD, PCD2, PCPlus4D, PCPlus4D2;
    logic        ValidD, ValidD2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallD(StallD), .FlushD(FlushD), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst2), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallD(StallD), .FlushD(FlushD), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2), .ValidD(ValidD2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant in one cycle, respond the next.
    task automatic do_fetch(input logic [31:0] d, input logic stall);
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        StallD      = stall;
        step();
        imem_rvalid = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        check_eq("rst_valid", 32'(ValidD), 32'd0);
        check_eq("rst_instr", InstrD, NOP);
        check_eq("rst_pcd", PCD, 32'h0);
        check_eq("rst_pc4d", PCPlus4D, 32'h0);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst2_valid", 32'(ValidD2), 32'd0);
        rst = 1'b1;
        step();
        check_eq("idle_req", 32'(imem_req), 32'd1);
        check_eq("first_addr", imem_addr, 32'h0);

        // Basic fetch stream
        imem_gnt = 1'b1;
        step();
        check_eq("wait_req", 32'(imem_req), 32'd0);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        step();
        imem_rvalid = 1'b0;
        check_eq("f1_instr", InstrD, 32'h0050_0093);
        check_eq("f1_pcd", PCD, 32'h0);
        check_eq("f1_pc4d", PCPlus4D, 32'h4);
        check_eq("f1_valid", 32'(ValidD), 32'd1);
        check_eq("f1_next_addr", imem_addr, 32'h4);
        check_eq("f1_next_req", 32'(imem_req), 32'd1);
        do_fetch(32'h0010_0113, 1'b0);
        check_eq("f2_pcd", PCD, 32'h4);
        check_eq("f2_next_addr", imem_addr, 32'h8);

        // Decode stall across response
        StallD   = 1'b1;
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0020_0193;
        step();
        imem_rvalid = 1'b0;
        step();
        step();
        check_eq("stall_req", 32'(imem_req), 32'd0);
        check_eq("stall_instr", InstrD, 32'h0010_0113);
        check_eq("stall_pcd", PCD, 32'h4);
        check_eq("stall_valid", 32'(ValidD), 32'd1);
        StallD = 1'b0;
        step();
        check_eq("release_instr", InstrD, 32'h0020_0193);
        check_eq("release_pcd", PCD, 32'h8);
        check_eq("release_pc4d", PCPlus4D, 32'hC);
        check_eq("release_valid", 32'(ValidD), 32'd1);
        check_eq("release_req", 32'(imem_req), 32'd1);
        check_eq("release_addr", imem_addr, 32'hC);

        // Redirect during WAIT, response arrives later
        imem_gnt = 1'b1;
        step();
        imem_gnt  = 1'b0;
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0103;
        step();
        PCSrcE      = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check_eq("kill_addr", imem_addr, 32'h100);
        check_eq("kill_req", 32'(imem_req), 32'd1);
        check_eq("kill_instr", InstrD, NOP);
        check_eq("kill_pcd", PCD, 32'h8);
        do_fetch(32'h00A0_0113, 1'b0);
        check_eq("post_kill_pcd", PCD, 32'h100);
        check_eq("post_kill_instr", InstrD, 32'h00A0_0113);
        check_eq("post_kill_addr", imem_addr, 32'h104);

        // Redirect coinciding with rvalid
        imem_gnt = 1'b1;
        step();
        imem_gnt    = 1'b0;
        PCSrcE      = 1'b1;
        PCTargetE   = 32'h0000_0200;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        step();
        PCSrcE      = 1'b0;
        imem_rvalid = 1'b0;
        check_eq("same_cyc_addr", imem_addr, 32'h200);
        check_eq("same_cyc_valid", 32'(ValidD), 32'd0);
        do_fetch(32'h00B0_0193, 1'b0);
        check_eq("same_cyc_next_pcd", PCD, 32'h200);
        check_eq("same_cyc_next_valid", 32'(ValidD), 32'd1);

        // Flush together with stall
        FlushD = 1'b1;
        StallD = 1'b1;
        step();
        FlushD = 1'b0;
        StallD = 1'b0;
        check_eq("flush_valid", 32'(ValidD), 32'd0);
        check_eq("flush_instr", InstrD, NOP);

        // Redirect while REQ is not yet granted: address must stay put
        PCSrcE    = 1'b1;
        PCTargetE = 32'h0000_0300;
        step();
        PCSrcE = 1'b0;
        check_eq("req_redir_addr", imem_addr, 32'h204);
        check_eq("req_redir_req", 32'(imem_req), 32'd1);
        do_fetch(32'h1111_1111, 1'b0);
        check_eq("req_redir_drop", InstrD, NOP);
        check_eq("req_redir_new_addr", imem_addr, 32'h300);

        // Reset while in WAIT, stale response after release
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst = 1'b0;
        #2;
        check_eq("mid_rst_pcd", PCD, 32'h0);
        check_eq("mid_rst_req", 32'(imem_req), 32'd0);
        rst         = 1'b1;
        rst2        = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        step();
        check_eq("stale_valid", 32'(ValidD), 32'd0);
        check_eq("stale_instr", InstrD, NOP);
        check_eq("stale_addr", imem_addr, 32'h0);
        check_eq("wrap_first_addr", imem_addr2, 32'hFFFF_FFFC);
        step();
        imem_rvalid = 1'b0;
        check_eq("unsolicited_req", 32'(imem_req), 32'd1);
        check_eq("unsolicited_valid", 32'(ValidD), 32'd0);

        // Fetch after reset, plus PC wrap on the second instance
        do_fetch(32'h0010_0073, 1'b0);
        check_eq("after_rst_pcd", PCD, 32'h0);
        check_eq("after_rst_addr", imem_addr, 32'h4);
        check_eq("wrap_pcd", PCD2, 32'hFFFF_FFFC);
        check_eq("wrap_pc4d", PCPlus4D2, 32'h0);
        check_eq("wrap_valid", 32'(ValidD2), 32'd1);
        check_eq("wrap_next_addr", imem_addr2, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
